// File: rtl/ptch_integ_pkg.sv
// Shared types, constants and saturation helpers for the pitch integrator.
package ptch_integ_pkg;

   typedef enum logic {
      ST_CAL = 1'b0,
      ST_RUN = 1'b1
   } state_t;

   localparam int unsigned PTCH_INT_W = 27;
   localparam int unsigned PTCH_SHIFT = 11;
   localparam int unsigned ACC_GAIN   = 327;
   localparam int unsigned ACC_SHIFT  = 13;

   // Clamp a 17-bit signed value into 16 bits.
   function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
      if (x[16] != x[15])
         return x[16] ? 16'sh8000 : 16'sh7FFF;
      else
         return x[15:0];
   endfunction

   // Clamp a 29-bit signed value into the 27-bit integrator range.
   function automatic logic signed [26:0] sat27(input logic signed [28:0] x);
      if ((x[28:26] != 3'b000) && (x[28:26] != 3'b111))
         return x[28] ? {1'b1, 26'b0} : {1'b0, {26{1'b1}}};
      else
         return x[26:0];
   endfunction

endpackage

// File: rtl/gyro_offset_cal.sv
// Averages 2^CAL_SMPLS_LOG2 raw gyro samples into a signed offset.
module gyro_offset_cal
   import ptch_integ_pkg::*;
#(
   parameter int unsigned CAL_SMPLS_LOG2 = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic signed [15:0] ptch_rt_raw,
   input  logic               clr,
   output logic signed [15:0] offset,
   output logic               done
);

   localparam int unsigned SUM_W = 16 + CAL_SMPLS_LOG2;

   logic signed [SUM_W-1:0]    cal_sum;
   logic signed [SUM_W-1:0]    sum_next;
   logic [CAL_SMPLS_LOG2-1:0]  cal_cnt;

   // Running sum including the current sample; the final average comes from this.
   always_comb begin
      sum_next = cal_sum + SUM_W'(ptch_rt_raw);
   end

   // Combinational so the caller can switch state on the same edge the offset loads.
   assign done = vld && !clr && (cal_cnt == '1);

   // Accumulate samples, latch the average on the last one; offset survives clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cal_sum <= '0;
         cal_cnt <= '0;
         offset  <= '0;
      end else if (clr) begin
         cal_sum <= '0;
         cal_cnt <= '0;
      end else if (vld) begin
         cal_cnt <= cal_cnt + 1'b1;
         if (cal_cnt == '1) begin
            cal_sum <= '0;
            offset  <= sum_next[SUM_W-1 -: 16];
         end else begin
            cal_sum <= sum_next;
         end
      end
   end

endmodule

// File: rtl/ptch_integrator.sv
// Gyro offset calibration followed by rate integration fused with accel pitch.
module ptch_integrator
   import ptch_integ_pkg::*;
#(
   parameter int unsigned        CAL_SMPLS_LOG2 = 4,
   parameter logic signed [15:0] AZ_OFFSET      = 16'sh00A0,
   parameter int unsigned        FUSION_GAIN    = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic signed [15:0] ptch_rt_raw,
   input  logic signed [15:0] AZ,
   input  logic               cal_req,
   output logic signed [15:0] ptch,
   output logic signed [15:0] ptch_rt,
   output logic               vld_out,
   output logic               cal_done
);

   state_t state, state_nxt;

   logic                          cal_vld;
   logic                          cal_fin;
   logic                          run_smpl;
   logic signed [15:0]            offset;
   logic signed [PTCH_INT_W-1:0]  ptch_int;
   logic signed [PTCH_INT_W-1:0]  int_new;
   logic signed [PTCH_INT_W+1:0]  int_sum;
   logic signed [PTCH_INT_W+1:0]  fusion;
   logic signed [16:0]            rt_diff;
   logic signed [16:0]            az_diff;
   logic signed [15:0]            rt_new;
   logic signed [15:0]            az_sat;
   logic signed [15:0]            ptch_acc;
   logic signed [15:0]            ptch_new;
   logic signed [25:0]            acc_prod;

   assign cal_vld  = vld && (state == ST_CAL);
   assign run_smpl = vld && !cal_req && (state == ST_RUN);

   gyro_offset_cal #(
      .CAL_SMPLS_LOG2(CAL_SMPLS_LOG2)
   ) u_cal (
      .clk         (clk),
      .rst         (rst),
      .vld         (cal_vld),
      .ptch_rt_raw (ptch_rt_raw),
      .clr         (cal_req),
      .offset      (offset),
      .done        (cal_fin)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_CAL;
      else     state <= state_nxt;
   end

   // Next state: cal_req always restarts calibration; CAL leaves on the last sample.
   always_comb begin
      state_nxt = state;
      if (cal_req)
         state_nxt = ST_CAL;
      else if ((state == ST_CAL) && cal_fin)
         state_nxt = ST_RUN;
   end

   // Per-sample datapath: compensated rate, accel pitch, fusion nudge, integrator.
   always_comb begin
      rt_diff  = 17'(ptch_rt_raw) - 17'(offset);
      rt_new   = sat16(rt_diff);
      az_diff  = 17'(AZ) - 17'(AZ_OFFSET);
      az_sat   = sat16(az_diff);
      acc_prod = 26'(az_sat) * 26'(ACC_GAIN);
      // Arithmetic shift then truncate: yields product bits [25:13] sign-extended.
      ptch_acc = 16'(acc_prod >>> ACC_SHIFT);
      fusion   = '0;
      if (ptch_acc > ptch)
         fusion = (PTCH_INT_W+2)'(FUSION_GAIN);
      else if (ptch_acc < ptch)
         fusion = -((PTCH_INT_W+2)'(FUSION_GAIN));
      int_sum  = (PTCH_INT_W+2)'(ptch_int) - (PTCH_INT_W+2)'(rt_new) + fusion;
      int_new  = sat27(int_sum);
      ptch_new = int_new[PTCH_INT_W-1 -: 16];
   end

   // Output and integrator registers; cal_req clears them and drops the sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptch_int <= '0;
         ptch     <= '0;
         ptch_rt  <= '0;
         vld_out  <= 1'b0;
         cal_done <= 1'b0;
      end else begin
         vld_out  <= run_smpl;
         cal_done <= (state_nxt == ST_RUN);
         if (cal_req) begin
            ptch_int <= '0;
            ptch     <= '0;
            ptch_rt  <= '0;
         end else if (run_smpl) begin
            ptch_int <= int_new;
            ptch     <= ptch_new;
            ptch_rt  <= rt_new;
         end
      end
   end

endmodule

// File: tb/tb_ptch_integrator.sv
// Self-checking bench for ptch_integrator: arithmetic reference model plus directed vectors.
module tb_ptch_integrator;

   logic               clk = 1'b0;
   logic               rst;
   logic               vld;
   logic signed [15:0] ptch_rt_raw;
   logic signed [15:0] AZ;
   logic               cal_req;
   logic signed [15:0] ptch;
   logic signed [15:0] ptch_rt;
   logic               vld_out;
   logic               cal_done;

   int tests  = 0;
   int failed = 0;
   bit cmp_en = 1'b0;

   localparam longint INT_MAX = 67108863;
   localparam longint INT_MIN = -67108864;

   ptch_integrator #(
      .CAL_SMPLS_LOG2 (4),
      .AZ_OFFSET      (16'sh00A0),
      .FUSION_GAIN    (1024)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vld         (vld),
      .ptch_rt_raw (ptch_rt_raw),
      .AZ          (AZ),
      .cal_req     (cal_req),
      .ptch        (ptch),
      .ptch_rt     (ptch_rt),
      .vld_out     (vld_out),
      .cal_done    (cal_done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (plain integer arithmetic) ----------------
   bit     m_run, m_vo, m_cd;
   int     m_cnt;
   longint m_sum, m_off, m_int, m_ptch, m_rt;

   function automatic longint clampl(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   always @(posedge clk or posedge rst) begin
      longint rt, acc, fus;
      if (rst) begin
         m_run = 0; m_vo = 0; m_cd = 0; m_cnt = 0;
         m_sum = 0; m_off = 0; m_int = 0; m_ptch = 0; m_rt = 0;
      end else begin
         m_vo = 0;
         if (cal_req) begin
            m_run = 0; m_cd = 0; m_cnt = 0; m_sum = 0;
            m_int = 0; m_ptch = 0; m_rt = 0;
         end else if (vld) begin
            if (!m_run) begin
               m_sum = m_sum + longint'(ptch_rt_raw);
               m_cnt = m_cnt + 1;
               if (m_cnt == 16) begin
                  m_off = fdiv(m_sum, 16);
                  m_run = 1; m_cd = 1; m_cnt = 0; m_sum = 0;
               end
            end else begin
               rt  = clampl(longint'(ptch_rt_raw) - m_off, -32768, 32767);
               acc = fdiv(clampl(longint'(AZ) - 160, -32768, 32767) * 327, 8192);
               fus = (acc > m_ptch) ? 1024 : ((acc < m_ptch) ? -1024 : 0);
               m_int  = clampl(m_int - rt + fus, INT_MIN, INT_MAX);
               m_ptch = fdiv(m_int, 2048);
               m_rt   = rt;
               m_vo   = 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, away from the rising edge, outputs must match the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_ptch",     longint'(ptch),     m_ptch);
         chk("cyc_ptch_rt",  longint'(ptch_rt),  m_rt);
         chk("cyc_vld_out",  longint'(vld_out),  longint'(m_vo));
         chk("cyc_cal_done", longint'(cal_done), longint'(m_cd));
      end
   end

   task automatic step(input logic v, input logic signed [15:0] r,
                       input logic signed [15:0] a, input logic c);
      vld = v; ptch_rt_raw = r; AZ = a; cal_req = c;
      @(posedge clk);
      #1;
      vld = 1'b0; cal_req = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; vld = 1'b0; cal_req = 1'b0;
      ptch_rt_raw = '0; AZ = 16'sh00A0;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ptch",     longint'(ptch),     0);
      chk("reset_cal_done", longint'(cal_done), 0);
      chk("reset_vld_out",  longint'(vld_out),  0);
      rst = 1'b0;

      // Calibration: 16 samples of 0x0010.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'sh0010, 16'sh00A0, 1'b0);
         chk("cal_vld_out", longint'(vld_out), 0);
         if (i < 15) chk("cal_done_early", longint'(cal_done), 0);
      end
      chk("cal_done_rise", longint'(cal_done), 1);
      chk("model_offset", m_off, 16);

      // Zero motion with idle gaps between some samples.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'sh0010, 16'sh00A0, 1'b0);
         chk("zero_vld_out", longint'(vld_out), 1);
         chk("zero_ptch_rt", longint'(ptch_rt), 0);
         chk("zero_ptch",    longint'(ptch),    0);
         if (i % 3 == 0) begin
            step(1'b0, 16'sh0010, 16'sh00A0, 1'b0);
            chk("zero_idle_vld_out", longint'(vld_out), 0);
         end
      end

      // Rate integration: 21 back-to-back samples of 0x0810.
      step(1'b1, 16'sh0810, 16'sh00A0, 1'b0);
      chk("rate_ptch_rt", longint'(ptch_rt), 2048);
      chk("rate_first_ptch", longint'(ptch), -1);
      chk("rate_first_int", m_int, -2048);
      for (int i = 1; i < 21; i++) step(1'b1, 16'sh0810, 16'sh00A0, 1'b0);
      chk("rate_last_ptch", longint'(ptch), -11);
      chk("rate_last_int", m_int, -22528);

      // Saturation: most-negative raw rate, integrator climbs to the positive clamp.
      step(1'b1, 16'sh8000, 16'sh00A0, 1'b0);
      chk("sat_ptch_rt", longint'(ptch_rt), -32768);
      n = 0;
      while (m_int != INT_MAX && n < 6000) begin
         step(1'b1, 16'sh8000, 16'sh00A0, 1'b0);
         n++;
      end
      chk("sat_pos_int", m_int, INT_MAX);
      repeat (3) step(1'b1, 16'sh8000, 16'sh00A0, 1'b0);
      chk("sat_pos_ptch", longint'(ptch), 32767);
      // Large positive rate drives it to the negative clamp.
      n = 0;
      while (m_int != INT_MIN && n < 6000) begin
         step(1'b1, 16'sh7FFF, 16'sh00A0, 1'b0);
         n++;
      end
      chk("sat_neg_int", m_int, INT_MIN);
      repeat (3) step(1'b1, 16'sh7FFF, 16'sh00A0, 1'b0);
      chk("sat_neg_ptch", longint'(ptch), -32768);

      // Accel path: large and saturating AZ values.
      step(1'b1, 16'sh0010, 16'sh0200, 1'b0);
      step(1'b1, 16'sh0010, 16'sh8000, 1'b0);
      step(1'b1, 16'sh0010, 16'sh7FFF, 1'b0);

      // Recalibration: cal_req together with vld drops the sample.
      step(1'b1, 16'sh0810, 16'sh00A0, 1'b1);
      chk("recal_vld_out",  longint'(vld_out),  0);
      chk("recal_ptch",     longint'(ptch),     0);
      chk("recal_cal_done", longint'(cal_done), 0);
      for (int i = 0; i < 16; i++) step(1'b1, 16'sh0020, 16'sh1234, 1'b0);
      chk("recal_done", longint'(cal_done), 1);
      chk("model_recal_offset", m_off, 32);
      step(1'b1, 16'sh0020, 16'sh00A0, 1'b0);
      chk("recal_ptch_rt_zero", longint'(ptch_rt), 0);
      step(1'b1, 16'sh0030, 16'sh0200, 1'b0);
      chk("recal_ptch_rt", longint'(ptch_rt), 16);

      // Async reset mid-RUN clears outputs without a clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_run_ptch_rt",  longint'(ptch_rt),  0);
      chk("rst_run_cal_done", longint'(cal_done), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Async reset mid-CAL after 7 samples: a full fresh 16 are then needed.
      for (int i = 0; i < 7; i++) step(1'b1, 16'sh0100, 16'sh00A0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("rst_cal_ptch",     longint'(ptch),     0);
      chk("rst_cal_cal_done", longint'(cal_done), 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 15; i++) step(1'b1, 16'sh0010, 16'sh00A0, 1'b0);
      chk("rst_cal_not_done", longint'(cal_done), 0);
      step(1'b1, 16'sh0010, 16'sh00A0, 1'b0);
      chk("rst_cal_done", longint'(cal_done), 1);
      step(1'b1, 16'sh0010, 16'sh00A0, 1'b0);
      chk("rst_cal_ptch_rt", longint'(ptch_rt), 0);

      @(posedge clk); #1;
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
